// File: rtl/demultiplexer_1x4.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : demultiplexer_1x4
// Description : Registered 1-to-4 stream demultiplexer. One valid/ready input
//               is steered to one of four valid/ready output channels chosen
//               by a 2-bit select. Broadcast mode loads all four channels at
//               once. Each channel has a single-entry holding register and a
//               wrapping delivered-word counter for debug.
//
// Ports       : clk                  rising-edge clock
//               rst_n                asynchronous active-low reset
//               in_valid/in_ready    upstream handshake (in_ready is combinational)
//               in_data [WIDTH]      upstream word
//               s [2]                destination channel select
//               bcast                1 = deliver to all four channels, overrides s
//               out_valid [4]        per-channel holding register full
//               out_ready [4]        per-channel consumer accept
//               out_data0..3 [WIDTH] per-channel holding registers
//               cnt0..3 [CNT_W]      per-channel delivered-word counters
//
// Revision    : 1.0  initial release
// ============================================================================
module demultiplexer_1x4 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       s,
  input  logic             bcast,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  localparam int c_NUM_CH = 4;

  logic [c_NUM_CH-1:0] r_valid;
  logic [WIDTH-1:0]    r_data [c_NUM_CH];
  logic [CNT_W-1:0]    r_cnt  [c_NUM_CH];

  logic [c_NUM_CH-1:0] w_free;
  logic [c_NUM_CH-1:0] w_drain;
  logic [c_NUM_CH-1:0] w_load;
  logic                w_all_free;
  logic                w_sel_free;
  logic                w_in_fire;

  // A channel can take a word if it is empty or is being emptied this cycle;
  // the latter gives back-to-back throughput through the single entry.
  assign w_free     = ~r_valid | out_ready;
  assign w_drain    = r_valid & out_ready;
  assign w_all_free = &w_free;
  assign w_sel_free = w_free[s];

  // Broadcast is all-or-nothing: a single stalled channel holds the word.
  // in_data is deliberately absent from this path.
  assign in_ready  = bcast ? w_all_free : w_sel_free;
  assign w_in_fire = in_valid & in_ready;

  generate
    for (genvar k = 0; k < c_NUM_CH; k++) begin : g_load
      assign w_load[k] = w_in_fire & (bcast | (s == 2'(k)));
    end
  endgenerate

  // Holding registers and valid flags. A load wins over a drain so that a
  // channel being emptied and refilled in the same cycle stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < c_NUM_CH; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < c_NUM_CH; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= in_data;
        end else if (w_drain[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Delivered-word counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < c_NUM_CH; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < c_NUM_CH; k++) begin
        if (w_drain[k]) begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];
  assign cnt0      = r_cnt[0];
  assign cnt1      = r_cnt[1];
  assign cnt2      = r_cnt[2];
  assign cnt3      = r_cnt[3];

endmodule
`default_nettype wire

// File: doc/demultiplexer_1x4.md
# demultiplexer_1x4

Registered 1-to-4 stream demultiplexer: accepts one word per cycle on a valid/ready input and steers it to one of four valid/ready output channels chosen by a 2-bit select, or to all four at once in broadcast mode. It is the receiving end of the team's multiplexer datapath, fanning a shared stream back out to per-channel consumers. Each output channel has a single-entry holding register, and the block keeps a per-channel delivered-word counter for debug.

## Interface
- WIDTH, 8, data width of input and all output channels
- CNT_W, 8, width of each per-channel delivered-word counter
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word present
- in_ready  output  1  block accepts word this cycle (combinational)
- in_data  input  WIDTH  upstream word
- s  input  2  destination channel select, sampled with in_data
- bcast  input  1  1 = deliver word to all four channels; overrides s
- out_valid  output  4  bit k: channel k holding register full
- out_ready  input  4  bit k: channel k consumer accepts
- out_data0..out_data3  output  WIDTH each  channel holding registers
- cnt0..cnt3  output  CNT_W each  words delivered to consumer on channel k

## Operation
- Channel k can accept when free_k = !out_valid[k] | out_ready[k].
- Unicast (bcast=0): in_ready = free_s. Broadcast (bcast=1): in_ready = free_0 & free_1 & free_2 & free_3. No partial broadcast.
- An input transfer occurs when in_valid & in_ready. On a unicast transfer, out_data_s <= in_data and out_valid[s] <= 1. On a broadcast transfer, all four channels load in_data and all out_valid bits go to 1.
- Output transfer on channel k occurs when out_valid[k] & out_ready[k]. It clears out_valid[k] unless a new word loads channel k in the same cycle. In that case out_valid[k] stays 1 and out_data_k takes the new word, giving back-to-back throughput.
- Channels are independent. A stalled channel never blocks unicast traffic to other channels. It does block broadcast.
- out_data_k holds its value while out_valid[k]=1 and out_ready[k]=0. The data is stable and valid is never withdrawn.
- cnt_k increments by 1 on each output transfer on channel k and wraps from 2^CNT_W-1 to 0.
- s and bcast are ignored when in_valid=0.

## Timing
- Latency: word accepted in cycle N is visible on out_valid/out_data in cycle N+1.
- Throughput: 1 word/cycle sustained when the destination out_ready is held high.
- in_ready is combinational from out_valid, out_ready, s and bcast. It has no combinational path from in_data.
- Reset (rst_n low, asynchronous): out_valid=0, out_data0..3=0, cnt0..3=0, regardless of clk. Any word in flight is discarded.
- Reset deassertion: the first transfer can be accepted on the first rising edge after rst_n rises.
- Reset asserted mid-operation: outputs clear immediately. Downstream must treat dropped valids as lost words.

## Test plan
- Reset: drive out_ready=4'b0000 and push 0xA5 to s=2, then assert rst_n low between edges. Required: out_valid drops to 0 immediately, out_data2=0 and cnt2=0, without waiting for a clk edge.
- Unicast steering: out_ready=4'b1111, send 0x11,0x22,0x33,0x44 with s=0,1,2,3 on consecutive cycles. Required: each word appears on the matching channel exactly one cycle after acceptance. cnt0..3 all equal 1 after the last word drains.
- Backpressure and hold: out_ready[1]=0, send 0x5A to s=1 and then 0x6B to s=1. Required:
  - out_data1=0x5A holds stable with out_valid[1]=1.
  - in_ready=0 while 0x6B waits, and a concurrent send to s=3 is still accepted.
  - After raising out_ready[1], 0x6B is accepted in that same cycle and appears the next cycle with no bubble.
- Broadcast: with all channels empty, send 0xC3 with bcast=1. Required: all four out_valid=1 and all data=0xC3 next cycle. Then hold out_ready[2]=0 and send another broadcast. Required: in_ready=0 and nothing loads until channel 2 drains.
- Streaming throughput: out_ready[0]=1, send 256 words 0..255 to s=0 back-to-back. Required:
  - in_ready stays 1 throughout.
  - Output sequence matches input order with 1-cycle latency.
  - cnt0 wraps to 0 after 256 deliveries (CNT_W=8).
- Random stress: 10k cycles of random in_valid, s, bcast and out_ready. A scoreboard checks per-channel order, no loss, no duplication, and cnt_k equal to observed output transfers modulo 2^CNT_W.
